sdram_rd_buf: RTL and testbench

//  Read-side buffer controller directly upstream of sdram_rd.
//  - Keeps an internal FIFO topped up from the SDRAM frame buffer.
//  - Issues burst read requests (rd_en / rd_addr / rd_burst_len) and stores the
//    rd_ack-qualified rd_sdram_data returned by sdram_rd.
//  - The display side drains the FIFO; the frame-sync input rewinds the address.

---
 rtl/sdram_rd_buf.sv | 133 +++++++++++++
 tb/tb_sdram_rd_buf.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rd_buf.sv
// Read-side frame buffer controller: keeps a FIFO topped up with SDRAM bursts
// through sdram_rd and lets the display side drain it. A frame sync rewinds the address.
module sdram_rd_buf #(
  parameter int          DATA_W     = 16,
  parameter logic [9:0]  BURST_LEN  = 10'd64,
  parameter int          FIFO_DEPTH = 256,
  parameter logic [23:0] ADDR_BEGIN = 24'd0,
  parameter logic [23:0] ADDR_END   = 24'd307200
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic                            init_end,
  input  logic                            rd_valid,
  input  logic                            frame_sync,
  output logic                            rd_en,
  output logic [23:0]                     rd_addr,
  output logic [9:0]                      rd_burst_len,
  input  logic                            rd_ack,
  input  logic [DATA_W-1:0]               rd_sdram_data,
  input  logic                            rd_end,
  input  logic                            fifo_rd_en,
  output logic [DATA_W-1:0]               fifo_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_num,
  output logic                            fifo_empty,
  output logic                            overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_reg;
  logic              pending_sync_reg;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              flush;
  logic              start_req;
  logic [31:0]       free_space;
  logic [24:0]       next_addr;
  logic              addr_wrap;

  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign push       = rd_ack && !fifo_full;
  assign pop        = fifo_rd_en && (count_reg != '0);
  // A sync seen on the same cycle as rd_end is honoured immediately rather than lost.
  assign flush      = ((state_reg == IDLE) && frame_sync) ||
                      ((state_reg == REQ) && rd_end && (pending_sync_reg || frame_sync));
  assign free_space = 32'(FIFO_DEPTH) - 32'(count_reg);
  // Whole-burst reservation: the burst can never overrun the FIFO, pops only add room.
  assign start_req  = init_end && rd_valid && !frame_sync && (free_space >= 32'(BURST_LEN));
  assign next_addr  = {1'b0, rd_addr} + 25'(BURST_LEN);
  assign addr_wrap  = (next_addr >= {1'b0, ADDR_END});

  assign rd_burst_len = BURST_LEN;
  assign fifo_num     = count_reg;
  assign fifo_empty   = (count_reg == '0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg        <= IDLE;
      rd_en            <= 1'b0;
      rd_addr          <= ADDR_BEGIN;
      pending_sync_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (frame_sync) begin
            rd_addr <= ADDR_BEGIN;
          end else if (start_req) begin
            state_reg <= REQ;
            rd_en     <= 1'b1;
          end
        end
        REQ: begin
          if (rd_end) begin
            state_reg        <= IDLE;
            rd_en            <= 1'b0;
            pending_sync_reg <= 1'b0;
            if (pending_sync_reg || frame_sync || addr_wrap)
              rd_addr <= ADDR_BEGIN;
            else
              rd_addr <= next_addr[23:0];
          end else if (frame_sync) begin
            pending_sync_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          rd_en     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push && !flush)
      mem[wr_ptr_reg] <= rd_sdram_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      fifo_rd_data <= '0;
      overflow     <= 1'b0;
    end else begin
      if (rd_ack && fifo_full)
        overflow <= 1'b1;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop) begin
          rd_ptr_reg   <= rd_ptr_reg + 1'b1;
          fifo_rd_data <= mem[rd_ptr_reg];
        end
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_sdram_rd_buf.sv
// Directed bench for sdram_rd_buf: the bench plays sdram_rd and the display side.
module tb_sdram_rd_buf;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic        rd_valid;
  logic        frame_sync;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [9:0]  rd_burst_len;
  logic        rd_ack;
  logic [15:0] rd_sdram_data;
  logic        rd_end;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data;
  logic [8:0]  fifo_num;
  logic        fifo_empty;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // Small frame region so the wrap is reached quickly: 5 bursts of 64 words.
  sdram_rd_buf #(
    .DATA_W(16), .BURST_LEN(10'd64), .FIFO_DEPTH(256),
    .ADDR_BEGIN(24'd0), .ADDR_END(24'd320)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .rd_valid(rd_valid),
    .frame_sync(frame_sync), .rd_en(rd_en), .rd_addr(rd_addr), .rd_burst_len(rd_burst_len),
    .rd_ack(rd_ack), .rd_sdram_data(rd_sdram_data), .rd_end(rd_end),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_num(fifo_num),
    .fifo_empty(fifo_empty), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        ack;
    logic [15:0] din;
    logic        pop;
    logic [8:0]  num;
    logic        empty;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input int max_cyc, input logic [23:0] exp_addr);
    int k;
    k = 0;
    while (rd_en !== 1'b1 && k < max_cyc) begin
      tick();
      k++;
    end
    chk("req_rd_en", {31'd0, rd_en}, 32'd1);
    chk("req_addr", {8'd0, rd_addr}, {8'd0, exp_addr});
  endtask

  task automatic send_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      rd_ack        = 1'b1;
      rd_sdram_data = base + 16'(i);
      tick();
    end
    rd_ack = 1'b0;
  endtask

  task automatic end_burst();
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
  endtask

  task automatic full_burst(input logic [15:0] base, input logic [23:0] exp_addr,
                            input logic [23:0] exp_next, input logic [8:0] exp_num);
    send_words(base, 64);
    chk("burst_hold_en", {31'd0, rd_en}, 32'd1);
    chk("burst_hold_addr", {8'd0, rd_addr}, {8'd0, exp_addr});
    end_burst();
    chk("burst_end_en", {31'd0, rd_en}, 32'd0);
    chk("burst_next_addr", {8'd0, rd_addr}, {8'd0, exp_next});
    chk("burst_num", {23'd0, fifo_num}, {23'd0, exp_num});
    $display("burst addr=%0d data_base=%0h -> next_addr=%0d fifo_num=%0d",
             exp_addr, base, rd_addr, fifo_num);
  endtask

  task automatic pop_check(input logic [15:0] base, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      fifo_rd_en = 1'b1;
      tick();
      chk(name, {16'd0, fifo_rd_data}, {16'd0, base + 16'(i)});
    end
    fifo_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b0, 16'h0000, 1'b1, 9'd0, 1'b1, 16'h103F};
    tbl[1] = '{1'b1, 16'hA000, 1'b0, 9'd1, 1'b0, 16'h103F};
    tbl[2] = '{1'b1, 16'hA001, 1'b0, 9'd2, 1'b0, 16'h103F};
    tbl[3] = '{1'b1, 16'hA002, 1'b1, 9'd2, 1'b0, 16'hA000};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 9'd1, 1'b0, 16'hA001};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 9'd0, 1'b1, 16'hA002};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 9'd0, 1'b1, 16'hA002};

    sys_rst = 1'b1; init_end = 1'b0; rd_valid = 1'b0; frame_sync = 1'b0;
    rd_ack = 1'b0; rd_sdram_data = '0; rd_end = 1'b0; fifo_rd_en = 1'b0;
    repeat (3) tick();
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_addr", {8'd0, rd_addr}, 32'd0);
    chk("rst_num", {23'd0, fifo_num}, 32'd0);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_rd_data", {16'd0, fifo_rd_data}, 32'd0);
    chk("burst_len", {22'd0, rd_burst_len}, 32'd64);

    // First burst and fill to four bursts with no pops
    sys_rst = 1'b0; init_end = 1'b1; rd_valid = 1'b1;
    wait_req(2, 24'd0);
    full_burst(16'h0000, 24'd0, 24'd64, 9'd64);
    wait_req(2, 24'd64);
    full_burst(16'h1000, 24'd64, 24'd128, 9'd128);
    wait_req(2, 24'd128);
    full_burst(16'h2000, 24'd128, 24'd192, 9'd192);
    wait_req(2, 24'd192);
    full_burst(16'h3000, 24'd192, 24'd256, 9'd256);
    repeat (5) tick();
    chk("full_no_req", {31'd0, rd_en}, 32'd0);
    chk("full_num", {23'd0, fifo_num}, 32'd256);

    // Pop the first burst in order; room opens for a fifth burst, which wraps
    pop_check(16'h0000, 64, "pop_data_b1");
    wait_req(2, 24'd256);
    full_burst(16'h5000, 24'd256, 24'd0, 9'd256);

    // Frame sync halfway through a burst: burst completes, then flush and rewind
    pop_check(16'h1000, 64, "pop_data_b2");
    wait_req(2, 24'd0);
    send_words(16'h6000, 32);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    send_words(16'h6020, 32);
    chk("sync_req_held", {31'd0, rd_en}, 32'd1);
    chk("sync_data_kept", {23'd0, fifo_num}, 32'd256);
    end_burst();
    chk("sync_num", {23'd0, fifo_num}, 32'd0);
    chk("sync_empty", {31'd0, fifo_empty}, 32'd1);
    chk("sync_addr", {8'd0, rd_addr}, 32'd0);
    chk("sync_rd_en", {31'd0, rd_en}, 32'd0);
    $display("frame_sync mid-burst -> fifo_num=%0d rd_addr=%0d", fifo_num, rd_addr);
    wait_req(2, 24'd0);

    // rd_valid drops during a burst: burst still completes, no further request
    send_words(16'h7000, 20);
    rd_valid = 1'b0;
    send_words(16'h7014, 44);
    chk("novalid_held", {31'd0, rd_en}, 32'd1);
    end_burst();
    chk("novalid_addr", {8'd0, rd_addr}, 32'd64);
    repeat (4) tick();
    chk("novalid_no_req", {31'd0, rd_en}, 32'd0);
    chk("novalid_num", {23'd0, fifo_num}, 32'd64);

    // Frame sync while idle
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("idle_sync_num", {23'd0, fifo_num}, 32'd0);
    chk("idle_sync_addr", {8'd0, rd_addr}, 32'd0);
    $display("frame_sync idle -> fifo_num=%0d rd_addr=%0d", fifo_num, rd_addr);

    // Table-driven push/pop vectors (no requests: rd_valid=0)
    for (int i = 0; i < 7; i++) begin
      rd_ack = tbl[i].ack; rd_sdram_data = tbl[i].din; fifo_rd_en = tbl[i].pop;
      tick();
      rd_ack = 1'b0; fifo_rd_en = 1'b0;
      chk($sformatf("vec%0d_num", i), {23'd0, fifo_num}, {23'd0, tbl[i].num});
      chk($sformatf("vec%0d_empty", i), {31'd0, fifo_empty}, {31'd0, tbl[i].empty});
      chk($sformatf("vec%0d_data", i), {16'd0, fifo_rd_data}, {16'd0, tbl[i].dout});
      $display("vec%0d ack=%0b pop=%0b -> num=%0d data=%0h", i, tbl[i].ack, tbl[i].pop,
               fifo_num, fifo_rd_data);
    end

    // Simultaneous push+pop at occupancy 10
    send_words(16'hB000, 10);
    chk("pp_pre_num", {23'd0, fifo_num}, 32'd10);
    rd_ack = 1'b1; rd_sdram_data = 16'hB00A; fifo_rd_en = 1'b1;
    tick();
    rd_ack = 1'b0; fifo_rd_en = 1'b0;
    chk("pp_num", {23'd0, fifo_num}, 32'd10);
    chk("pp_data", {16'd0, fifo_rd_data}, 32'h0000B000);

    // Fill to full, then a forced write sets the sticky overflow
    send_words(16'hC000, 246);
    chk("fill_num", {23'd0, fifo_num}, 32'd256);
    chk("fill_no_ovf", {31'd0, overflow}, 32'd0);
    rd_ack = 1'b1; rd_sdram_data = 16'hDEAD;
    tick();
    rd_ack = 1'b0;
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_num", {23'd0, fifo_num}, 32'd256);
    pop_check(16'hB001, 3, "ovf_pop_data");
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_pop_num", {23'd0, fifo_num}, 32'd253);

    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rst2_overflow", {31'd0, overflow}, 32'd0);
    chk("rst2_num", {23'd0, fifo_num}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
